// File: rtl/mult_seq_param.sv
// ---------------------------------------------------------------------------
// mult_seq_param
//
// Parametrised sequential shift-add multiplier. The operand magnitudes are
// captured at start, multiplied one multiplier bit per clock, and the sign is
// applied in a single SIGN step before the result is published. Done pulses
// for one cycle when Produto and Ovf update. Idle reports the IDLE state to
// the controller.
//
// Parameters
//   W           operand width (>= 2); the product is 2W bits
//   EARLY_EXIT  1 = leave CALC as soon as no multiplier bits remain set
//
// Ports
//   CLK            in   1   rising-edge clock
//   Reset          in   1   asynchronous, active-low reset
//   St             in   1   start request (accepted only when ready to start)
//   Signed         in   1   1 = two's-complement operands, 0 = unsigned
//   Multiplicando  in   W   multiplicand, captured with St
//   Multiplicador  in   W   multiplier, captured with St
//   Produto        out  2W  result register, updated only in SIGN
//   Ovf            out  1   result does not fit in W bits for the captured mode
//   Done           out  1   one-cycle pulse when Produto updates
//   Idle           out  1   high only in IDLE
// ---------------------------------------------------------------------------
module mult_seq_param #(
  parameter int W          = 32,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic           St,
  input  logic           Signed,
  input  logic [W-1:0]   Multiplicando,
  input  logic [W-1:0]   Multiplicador,
  output logic [2*W-1:0] Produto,
  output logic           Ovf,
  output logic           Done,
  output logic           Idle
);

  localparam int            CW       = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Operation context captured at start
  logic [2*W-1:0] mcand_sh;
  logic [W-1:0]   mplier_mag;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;
  logic           neg;
  logic           mode_signed;

  // Combinational helpers
  logic           start_ok;
  logic [W-1:0]   mcand_abs;
  logic [W-1:0]   mplier_abs;
  logic           start_neg;
  logic           calc_last;
  logic [2*W-1:0] acc_next;
  logic [2*W-1:0] result;
  logic           ovf_next;

  // Operand conditioning at start. The magnitude of the most negative value
  // (-2^(W-1)) is 2^(W-1), which the unsigned W-bit negation yields exactly.
  always_comb begin
    start_ok   = 1'b0;
    mcand_abs  = Multiplicando;
    mplier_abs = Multiplicador;
    start_neg  = 1'b0;
    if ((state == IDLE) || (state == DONE)) begin
      start_ok = St;
    end
    if (Signed) begin
      if (Multiplicando[W-1]) begin
        mcand_abs = -Multiplicando;
      end
      if (Multiplicador[W-1]) begin
        mplier_abs = -Multiplicador;
      end
      start_neg = Multiplicando[W-1] ^ Multiplicador[W-1];
    end
  end

  // Datapath arithmetic. The multiplicand is kept pre-shifted by the number of
  // steps already taken, which is the same as shifting by (W - cnt).
  // The last CALC step is the one that brings cnt to zero or, with early exit,
  // the one after which no set multiplier bits remain.
  always_comb begin
    acc_next = acc;
    if (mplier_mag[0]) begin
      acc_next = acc + mcand_sh;
    end

    calc_last = (cnt == CNT_ONE);
    if (EARLY_EXIT && (mplier_mag[W-1:1] == '0)) begin
      calc_last = 1'b1;
    end

    result = neg ? -acc : acc;

    // Signed results fit in W bits only if the upper W+1 bits are a pure
    // sign extension; unsigned results fit only if the upper half is zero.
    if (mode_signed) begin
      ovf_next = !(&result[2*W-1:W-1]) && (|result[2*W-1:W-1]);
    end else begin
      ovf_next = |result[2*W-1:W];
    end
  end

  // State register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. The closing edge of DONE is also a start opportunity so
  // that a held St sustains one result every W+2 cycles.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (St) begin
          state_next = CALC;
        end
      end
      CALC: begin
        if (calc_last) begin
          state_next = SIGN;
        end
      end
      SIGN: begin
        state_next = DONE;
      end
      DONE: begin
        state_next = St ? CALC : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operation context and result registers. Done defaults low every cycle so
  // it can only be a single-cycle pulse from SIGN.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      mcand_sh    <= '0;
      mplier_mag  <= '0;
      acc         <= '0;
      cnt         <= '0;
      neg         <= 1'b0;
      mode_signed <= 1'b0;
      Produto     <= '0;
      Ovf         <= 1'b0;
      Done        <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (start_ok) begin
        mcand_sh    <= {{W{1'b0}}, mcand_abs};
        mplier_mag  <= mplier_abs;
        acc         <= '0;
        cnt         <= CNT_INIT;
        neg         <= start_neg;
        mode_signed <= Signed;
      end else if (state == CALC) begin
        acc        <= acc_next;
        mcand_sh   <= mcand_sh << 1;
        mplier_mag <= mplier_mag >> 1;
        cnt        <= cnt - CNT_ONE;
      end else if (state == SIGN) begin
        Produto <= result;
        Ovf     <= ovf_next;
        Done    <= 1'b1;
      end
    end
  end

  assign Idle = (state == IDLE);

endmodule

// File: tb/tb_mult_seq_param.sv
// ---------------------------------------------------------------------------
// tb_mult_seq_param
//
// Three instances of the multiplier share one clock and reset:
//   u32 : W = 32, fixed latency
//   u16 : W = 16, early exit
//   u8  : W = 8,  fixed latency, used for back-to-back operation
// Stimulus pushes the expected product, overflow flag and the clock edge on
// which Done must appear into a per-instance queue; a monitor pops and
// compares whenever an instance raises Done.
// ---------------------------------------------------------------------------
module tb_mult_seq_param;

  typedef struct {
    logic [63:0] prod;
    bit          ovf;
    int          due;
  } exp_t;

  logic clk;
  logic rst_n;

  logic        st32, sg32, ovf32, done32, idle32;
  logic [31:0] a32, b32;
  logic [63:0] p32;

  logic        st16, sg16, ovf16, done16, idle16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  logic        st8, sg8, ovf8, done8, idle8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  exp_t q32[$];
  exp_t q16[$];
  exp_t q8[$];

  int cyc         = 0;
  int vectors     = 0;
  int miscompares = 0;
  int n_checks    = 0;
  bit prev32      = 1'b0;
  bit prev16      = 1'b0;
  bit prev8       = 1'b0;

  mult_seq_param #(.W(32), .EARLY_EXIT(1'b0)) u32 (
    .CLK(clk), .Reset(rst_n), .St(st32), .Signed(sg32),
    .Multiplicando(a32), .Multiplicador(b32),
    .Produto(p32), .Ovf(ovf32), .Done(done32), .Idle(idle32)
  );

  mult_seq_param #(.W(16), .EARLY_EXIT(1'b1)) u16 (
    .CLK(clk), .Reset(rst_n), .St(st16), .Signed(sg16),
    .Multiplicando(a16), .Multiplicador(b16),
    .Produto(p16), .Ovf(ovf16), .Done(done16), .Idle(idle16)
  );

  mult_seq_param #(.W(8), .EARLY_EXIT(1'b0)) u8 (
    .CLK(clk), .Reset(rst_n), .St(st8), .Signed(sg8),
    .Multiplicando(a8), .Multiplicador(b8),
    .Produto(p8), .Ovf(ovf8), .Done(done8), .Idle(idle8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: at a falling edge, cyc equals the number of rising edges so far
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // Reference: interpret the operands as integers, multiply, and judge
  // whether the mathematical product fits in a W-bit integer of that mode.
  // k is the 1-based position of the highest set multiplier magnitude bit.
  function automatic void refModel(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input bit sgn, output logic [63:0] prod,
                                   output bit ovf, output int k);
    logic signed [127:0] ax, bx, p, one, hi;
    logic [127:0]        mask;
    logic [63:0]         bm;
    one  = 128'sd1;
    mask = (128'd1 << w) - 128'd1;
    ax   = $signed({64'd0, a} & mask);
    bx   = $signed({64'd0, b} & mask);
    if (sgn && a[w-1]) ax = ax - (one << w);
    if (sgn && b[w-1]) bx = bx - (one << w);
    p    = ax * bx;
    prod = 64'(p & ((128'd1 << (2 * w)) - 128'd1));
    if (sgn) begin
      hi  = one << (w - 1);
      ovf = (p >= hi) || (p < -hi);
    end else begin
      ovf = (p >= (one << w));
    end
    bm = (bx < 0) ? 64'(-bx) : 64'(bx);
    k  = 1;
    for (int i = 0; i < w; i++) begin
      if (bm[i]) k = i + 1;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int which, input bit st, input bit sgn,
                       input logic [63:0] a, input logic [63:0] b);
    case (which)
      32: begin st32 = st; sg32 = sgn; a32 = a[31:0]; b32 = b[31:0]; end
      16: begin st16 = st; sg16 = sgn; a16 = a[15:0]; b16 = b[15:0]; end
      default: begin st8 = st; sg8 = sgn; a8 = a[7:0]; b8 = b[7:0]; end
    endcase
  endtask

  function automatic bit idleOf(input int which);
    case (which)
      32:      return idle32;
      16:      return idle16;
      default: return idle8;
    endcase
  endfunction

  task automatic waitIdle(input int which);
    int n = 0;
    while (!idleOf(which) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_checks++;
      miscompares++;
      $display("[TB] FAIL w%0d idle_timeout: got Idle=0, expected Idle=1 within 300 cycles", which);
    end
  endtask

  task automatic pushExp(input int which, input exp_t e);
    case (which)
      32:      q32.push_back(e);
      16:      q16.push_back(e);
      default: q8.push_back(e);
    endcase
    vectors++;
  endtask

  // Starts one operation at the next rising edge, then scrambles the inputs
  // while the operation is in flight.
  task automatic applyStimulus(input int which, input logic [63:0] a,
                               input logic [63:0] b, input bit sgn);
    exp_t e;
    int   k;
    waitIdle(which);
    drive(which, 1'b1, sgn, a, b);
    refModel(which, a, b, sgn, e.prod, e.ovf, k);
    e.due = cyc + 1 + ((which == 16) ? (k + 1) : (which + 1));
    pushExp(which, e);
    @(negedge clk);
    checkOutput($sformatf("w%0d busy_after_start", which), 64'(idleOf(which)), 64'd0);
    drive(which, 1'b0, ~sgn, {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  task automatic popCheck(input int which, input logic [63:0] prod, input bit ovf, input bit idle);
    exp_t e;
    bit   have = 1'b0;
    case (which)
      32:      if (q32.size() > 0) begin e = q32.pop_front(); have = 1'b1; end
      16:      if (q16.size() > 0) begin e = q16.pop_front(); have = 1'b1; end
      default: if (q8.size() > 0)  begin e = q8.pop_front();  have = 1'b1; end
    endcase
    if (!have) begin
      n_checks++;
      miscompares++;
      $display("[TB] FAIL w%0d unexpected_done: got Done=1, expected no pending result", which);
    end else begin
      checkOutput($sformatf("w%0d product", which), prod, e.prod);
      checkOutput($sformatf("w%0d ovf", which), 64'(ovf), 64'(e.ovf));
      checkOutput($sformatf("w%0d done_edge", which), 64'(cyc), 64'(e.due));
      checkOutput($sformatf("w%0d idle_while_done", which), 64'(idle), 64'd0);
    end
  endtask

  // Monitors: compare every Done pulse against the head of the queue and
  // make sure no pulse lasts longer than one cycle.
  always @(negedge clk) begin
    if (done32) begin
      checkOutput("w32 done_width", 64'(prev32), 64'd0);
      popCheck(32, p32, ovf32, idle32);
    end
    if (done16) begin
      checkOutput("w16 done_width", 64'(prev16), 64'd0);
      popCheck(16, {32'd0, p16}, ovf16, idle16);
    end
    if (done8) begin
      checkOutput("w8 done_width", 64'(prev8), 64'd0);
      popCheck(8, {48'd0, p8}, ovf8, idle8);
    end
    prev32 = done32;
    prev16 = done16;
    prev8  = done8;
  end

  task automatic waitDrain();
    int n = 0;
    while ((q32.size() + q16.size() + q8.size()) > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if ((q32.size() + q16.size() + q8.size()) > 0) begin
      n_checks++;
      miscompares++;
      $display("[TB] FAIL drain_timeout: got %0d results outstanding, expected 0",
               q32.size() + q16.size() + q8.size());
      q32.delete();
      q16.delete();
      q8.delete();
    end
  endtask

  initial begin
    logic [63:0] ra, rb;
    int          sh;
    int          e0;
    exp_t        e;
    int          k;
    bit          s;

    rst_n = 1'b0;
    drive(32, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(16, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(8,  1'b0, 1'b0, 64'd0, 64'd0);
    repeat (3) @(negedge clk);

    checkOutput("w32 reset_idle", 64'(idle32), 64'd1);
    checkOutput("w32 reset_done", 64'(done32), 64'd0);
    checkOutput("w32 reset_prod", p32, 64'd0);
    checkOutput("w32 reset_ovf",  64'(ovf32), 64'd0);
    checkOutput("w16 reset_idle", 64'(idle16), 64'd1);
    checkOutput("w8 reset_idle",  64'(idle8), 64'd1);

    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed operations");
    applyStimulus(32, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0);
    applyStimulus(32, 64'hFFFF_FFFD, 64'd7, 1'b1);
    applyStimulus(32, 64'h8000_0000, 64'h8000_0000, 1'b1);
    applyStimulus(32, 64'h8000_0000, 64'd1, 1'b1);
    applyStimulus(16, 64'h1234, 64'h0005, 1'b0);
    applyStimulus(16, 64'h1234, 64'h0000, 1'b0);
    applyStimulus(16, 64'h1234, 64'h0001, 1'b0);
    applyStimulus(16, 64'h8000, 64'h8000, 1'b1);
    applyStimulus(16, 64'h7FFF, 64'hFFFF, 1'b1);
    applyStimulus(8,  64'h80, 64'h80, 1'b1);
    applyStimulus(8,  64'hFF, 64'hFF, 1'b0);
    applyStimulus(8,  64'h0F, 64'hF1, 1'b1);

    $display("[TB] random operations");
    for (int i = 0; i < 10; i++) begin
      ra = 64'($urandom);
      rb = 64'($urandom);
      applyStimulus(32, ra, rb, 1'($urandom_range(0, 1)));
      sh = $urandom_range(0, 16);
      ra = 64'($urandom);
      rb = 64'($urandom) & ((64'd1 << sh) - 64'd1);
      applyStimulus(16, ra, rb, 1'($urandom_range(0, 1)));
      ra = 64'($urandom);
      rb = 64'($urandom);
      applyStimulus(8, ra, rb, 1'($urandom_range(0, 1)));
    end
    waitDrain();

    // St held high: captures happen at relative edges 0, 10 and 20 only,
    // while operands and mode change on every cycle.
    $display("[TB] back-to-back with St held");
    waitIdle(8);
    e0 = cyc + 1;
    for (int i = 0; i < 34; i++) begin
      ra = 64'($urandom);
      rb = 64'($urandom);
      s  = 1'($urandom_range(0, 1));
      drive(8, (i < 30), s, ra, rb);
      if ((i % 10) == 0 && i < 30) begin
        refModel(8, ra, rb, s, e.prod, e.ovf, k);
        e.due = e0 + i + 9;
        pushExp(8, e);
      end
      @(negedge clk);
    end
    drive(8, 1'b0, 1'b0, 64'd0, 64'd0);
    waitDrain();

    // Reset in the middle of CALC discards the operation immediately.
    $display("[TB] reset during calculation");
    applyStimulus(32, 64'h0001_2345, 64'h0000_6789, 1'b0);
    repeat (9) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("w32 midreset_idle", 64'(idle32), 64'd1);
    checkOutput("w32 midreset_done", 64'(done32), 64'd0);
    checkOutput("w32 midreset_prod", p32, 64'd0);
    checkOutput("w32 midreset_ovf",  64'(ovf32), 64'd0);
    q32.delete();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32, 64'hFFFF_FFF0, 64'h0000_0010, 1'b1);
    applyStimulus(32, 64'd1234, 64'd5678, 1'b0);
    waitDrain();

    $display("[TB] %0d comparisons made", n_checks);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
